spi_xfer_queue: RTL
===================

Name: spi_xfer_queue

Overview:
- Upstream feeder and collector for the team's SPI master (mode 0, one word per data_ready/data_sent handshake).
- Buffers outgoing words in a TX FIFO and issues them to the master one at a time over the full four-phase handshake.
- Stores each received word in an RX FIFO for the host logic.
- Host sees simple valid/ready streams; the master sees a well-behaved data_ready driver.

Parameters:
- BITS, 8, word width; must match the SPI master's BITS.
- DEPTH, 4, entries per FIFO (TX and RX each); power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tx_data  in  BITS  word to transmit
- tx_valid  in  1  host offers tx_data
- tx_ready  out  1  TX FIFO not full; push occurs when tx_valid && tx_ready
- rx_data  out  BITS  head of RX FIFO (show-ahead)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  host pops; pop occurs when rx_valid && rx_ready
- spi_data_in  out  BITS  word to master data_in; held stable while spi_data_ready=1
- spi_data_ready  out  1  to master data_ready
- spi_data_sent  in  1  from master data_sent
- spi_data_out  in  BITS  from master data_out; valid while spi_data_sent=1
- busy  out  1  FSM not in IDLE, or TX FIFO not empty
- rx_overflow  out  1  sticky: a received word was dropped (RX full)
- tx_level  out  $clog2(DEPTH+1)  TX occupancy, 0..DEPTH
- rx_level  out  $clog2(DEPTH+1)  RX occupancy, 0..DEPTH

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - Both FIFOs empty; pointers and levels 0.
  - tx_ready=1, rx_valid=0, rx_data=0.
  - spi_data_ready=0, spi_data_in=0.
  - busy=0, rx_overflow=0.
  - FSM in IDLE.
- FIFOs:
  - Circular buffers with read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - Level counters are separate registers.
  - tx_ready = (tx_level != DEPTH); rx_valid = (rx_level != 0). Both are derived from the registered levels.
  - Simultaneous push and pop on the same FIFO in one cycle: both take effect, level unchanged.
  - A push to a full FIFO, or a pop from an empty one, is impossible by construction. The RX write is gated as described under REQ.
- FSM states IDLE, REQ, RELEASE:
  - IDLE: if tx_level!=0 and spi_data_sent==0, then:
    - pop the TX head into spi_data_in;
    - spi_data_ready<=1;
    - go to REQ.
    - Otherwise stay, with spi_data_ready=0.
  - REQ: hold spi_data_ready=1 and spi_data_in. When spi_data_sent==1:
    - push spi_data_out into RX; if RX is full, drop the word and set rx_overflow<=1;
    - spi_data_ready<=0;
    - go to RELEASE.
  - RELEASE: spi_data_ready=0. When spi_data_sent==0, go to IDLE.
    - The master drops data_sent about 2 cycles after data_ready falls.
    - Never re-assert spi_data_ready before data_sent is observed low.
- Latency and throughput:
  - A word pushed in cycle N, with the FIFO previously empty and the FSM in IDLE, produces spi_data_ready=1 visible in cycle N+2.
  - Exactly one RX word is produced per TX word, in order.
- Host pop in the same cycle as the internal RX push: both are honoured.
  - This includes the case RX full: the pop frees the slot and the push is accepted, not dropped.
- rx_overflow clears only on rst.
- Reset mid-transfer: spi_data_ready drops to 0 on the reset edge and the in-flight word is lost.
  - The master is assumed to share rst.

Optional Feature:
- Macro: SPI_XFER_QUEUE_RX_STALL_EN.
- Defined: IDLE additionally requires rx_level != DEPTH before launching a transfer. RX can then never overflow; rx_overflow is tied 0.
- Undefined: behaviour as above, i.e. drop on full and set the sticky rx_overflow.

Test Plan:
- Single word, loopback:
  - Setup: SPI master with BITS=8 and miso tied to mosi.
  - Stimulus: push 0xA5.
  - Response: spi_data_ready high 2 cycles after the push; rx_valid asserts with rx_data=0xA5; tx_level returns to 0; busy returns to 0.
- Burst to full TX:
  - Stimulus: push 0x01,0x02,0x03,0x04 back-to-back with DEPTH=4 and no transfers draining yet.
  - Response: tx_ready=0 after the 4th push (tx_level=4). RX receives 01..04 in order, one per handshake.
  - Check: spi_data_ready never rises while spi_data_sent=1.
- RX overflow, macro undefined:
  - Stimulus: push 6 words 0x10..0x15 with rx_ready=0.
  - Response: rx_level saturates at 4; rx_overflow=1 after the 5th completion; popping yields 0x10..0x13.
- RX stall, macro defined:
  - Stimulus: same as the overflow scenario.
  - Response: after 4 completions the FSM stays in IDLE with tx_level=2 and rx_overflow=0. Popping one RX word resumes the transfers.
- Simultaneous pop and push on full RX:
  - Stimulus: RX full, with rx_ready=1 in the completion cycle.
  - Response: rx_level stays 4, no overflow, order preserved.
- Reset mid-transfer:
  - Stimulus: assert rst while in REQ.
  - Response: next cycle spi_data_ready=0, tx_level=0, rx_level=0, rx_overflow=0. A fresh push of 0x3C then completes normally.

Source files
------------

// File: rtl/spi_xfer_queue.sv
// TX/RX word queues feeding an SPI master over the data_ready/data_sent handshake.
// Optional build macro SPI_XFER_QUEUE_RX_STALL_EN: hold off new transfers while RX is full.
module spi_xfer_queue #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BITS-1:0]            tx_data,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic [BITS-1:0]            rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [BITS-1:0]            spi_data_in,
    output logic                       spi_data_ready,
    input  logic                       spi_data_sent,
    input  logic [BITS-1:0]            spi_data_out,
    output logic                       busy,
    output logic                       rx_overflow,
    output logic [$clog2(DEPTH+1)-1:0] tx_level,
    output logic [$clog2(DEPTH+1)-1:0] rx_level
);
    // state   | meaning
    // IDLE    | waiting for a TX word and data_sent low
    // REQ     | data_ready high, waiting for data_sent
    // RELEASE | data_ready low, waiting for data_sent to drop
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
    state_t state, state_nx;

    logic [BITS-1:0] tx_mem [DEPTH];
    logic [BITS-1:0] rx_mem [DEPTH];
    logic [AW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
    logic [LW-1:0]   tx_cnt, rx_cnt;
    logic            tx_push, tx_pop, rx_push, rx_pop, rx_accept, launch_ok;

    assign tx_level = tx_cnt;
    assign rx_level = rx_cnt;
    assign tx_ready = (tx_cnt != FULL);
    assign rx_valid = (rx_cnt != '0);
    assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;
    assign busy     = (state != IDLE) || (tx_cnt != '0);
    assign tx_push  = tx_valid && tx_ready;
    assign rx_pop   = rx_valid && rx_ready;
    // A host pop in the completion cycle frees the slot for the incoming word.
    assign rx_accept = rx_push && ((rx_cnt != FULL) || rx_pop);

`ifdef SPI_XFER_QUEUE_RX_STALL_EN
    assign launch_ok   = (tx_cnt != '0) && !spi_data_sent && (rx_cnt != FULL);
    assign rx_overflow = 1'b0;
`else
    logic ovf_q;
    assign launch_ok   = (tx_cnt != '0) && !spi_data_sent;
    assign rx_overflow = ovf_q;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (rx_push && !rx_accept)
            ovf_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        case (state)
            IDLE: begin
                if (launch_ok) begin
                    tx_pop   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (spi_data_sent) begin
                    rx_push  = 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: begin
                if (!spi_data_sent)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spi_data_ready <= 1'b0;
            spi_data_in    <= '0;
        end else if (tx_pop) begin
            spi_data_ready <= 1'b1;
            spi_data_in    <= tx_mem[tx_rd];
        end else if (rx_push) begin
            spi_data_ready <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr] <= tx_data;
        if (rx_accept)
            rx_mem[rx_wr] <= spi_data_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (tx_push)   tx_wr <= tx_wr + AW'(1);
            if (tx_pop)    tx_rd <= tx_rd + AW'(1);
            if (rx_accept) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)    rx_rd <= rx_rd + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + LW'(1);
                2'b01:   tx_cnt <= tx_cnt - LW'(1);
                default: ;
            endcase
            case ({rx_accept, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + LW'(1);
                2'b01:   rx_cnt <= rx_cnt - LW'(1);
                default: ;
            endcase
        end
    end
endmodule
